// File: rtl/p_int_seq_acc_pkg.sv
// Shared datapath types for the integer perceptron pipeline, plus the
// accumulator FSM state enum so benches can name the states.
package p_int_seq_acc_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
  } dconf_t;

  localparam dconf_t DefDconfInt = '{sign: 1'b1, prec: 8'd8};

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } acc_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_beat);
    return $clog2(max_beat + 1);
  endfunction

endpackage

// File: rtl/p_int_seq_acc_if.sv
// Beat-in / result-out handshake bundle of the sequential accumulator.
interface p_int_seq_acc_if #(
  parameter int unsigned Prec = 8,
  parameter int unsigned Cntw = 9
);
  logic            in_valid;
  logic            in_ready;
  logic [Prec-1:0] in_data;
  logic            in_ovf;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [Prec-1:0] out_data;
  logic            out_ovf;
  logic [Cntw-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_ovf, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_ovf, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_beats
  );
endinterface

// File: rtl/p_int_add.sv
// Two-operand wrapping integer adder with signed or unsigned overflow detection.
module p_int_add
  import p_int_seq_acc_pkg::*;
#(
  parameter dconf_t I1Conf = DefDconfInt,
  parameter dconf_t I2Conf = DefDconfInt,
  parameter dconf_t OConf  = DefDconfInt,
  localparam int unsigned Prec = {24'd0, OConf.prec}
) (
  input  logic [Prec-1:0] a_i,
  input  logic [Prec-1:0] b_i,
  output logic [Prec-1:0] sum_o,
  output logic            ovf_o
);
  logic [Prec:0] wide;

  assign wide  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = wide[Prec-1:0];

  // Signed: like-signed operands producing an opposite-signed result.
  always_comb begin
    ovf_o = 1'b0;
    if (OConf.sign) begin
      ovf_o = (a_i[Prec-1] == b_i[Prec-1]) && (sum_o[Prec-1] != a_i[Prec-1]);
    end else begin
      ovf_o = wide[Prec];
    end
  end
endmodule

// File: rtl/p_int_seq_acc.sv
// Accumulates adder-tree partial sums over a multi-beat vector and hands the
// total, sticky overflow and beat count downstream over valid/ready.
module p_int_seq_acc
  import p_int_seq_acc_pkg::*;
#(
  parameter dconf_t      Conf    = DefDconfInt,
  parameter int unsigned MaxBeat = 256,
  localparam int unsigned Prec   = {24'd0, Conf.prec},
  localparam int unsigned Cntw   = cnt_width(MaxBeat)
) (
  input logic           clk,
  input logic           reset,
  p_int_seq_acc_if.slave bus
);
  acc_state_e      state_q;
  logic [Prec-1:0] acc_q;
  logic [Prec-1:0] sum;
  logic            ovf_q;
  logic            add_ovf;
  logic [Cntw-1:0] cnt_q;
  logic [Cntw-1:0] cnt_inc;
  logic            fire;
  logic            first_beat;
  logic            at_max;

  p_int_add #(
    .I1Conf(Conf),
    .I2Conf(Conf),
    .OConf (Conf)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (bus.in_data),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );

  assign bus.in_ready  = !reset && (state_q != StDone || bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_beats = cnt_q;

  assign fire       = bus.in_valid && bus.in_ready;
  // A beat taken in DONE retires the result and starts a new vector on the same edge.
  assign first_beat = fire && (state_q != StAcc);
  assign cnt_inc    = cnt_q + Cntw'(1);
  assign at_max     = (cnt_inc == Cntw'(MaxBeat));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (first_beat) begin
      acc_q   <= bus.in_data;
      ovf_q   <= bus.in_ovf;
      cnt_q   <= Cntw'(1);
      state_q <= bus.in_last ? StDone : StAcc;
    end else if (fire) begin
      acc_q   <= sum;
      cnt_q   <= cnt_inc;
      // Cutting a vector short at MaxBeat is reported as overflow.
      ovf_q   <= ovf_q || bus.in_ovf || add_ovf || (at_max && !bus.in_last);
      state_q <= (bus.in_last || at_max) ? StDone : StAcc;
    end else if (state_q == StDone && bus.out_ready) begin
      state_q <= StIdle;
    end
  end
endmodule

// File: tb/tb_p_int_seq_acc.sv
// Directed bench for p_int_seq_acc: PREC=8 signed, MAXBEAT=4.
module tb_p_int_seq_acc;
  import p_int_seq_acc_pkg::*;

  localparam int unsigned MaxBeat = 4;
  localparam int unsigned Cntw    = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  p_int_seq_acc_if #(.Prec(8), .Cntw(Cntw)) bus ();

  p_int_seq_acc #(
    .Conf   (DefDconfInt),
    .MaxBeat(MaxBeat)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input string tag, input logic [7:0] d, input logic ovf,
                           input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ovf   = ovf;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_ovf   = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] d, input logic ovf,
                               input logic [Cntw-1:0] beats);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(d));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
    check({tag, "_beats"}, 32'(bus.out_beats), 32'(beats));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ovf    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst_out_beats", 32'(bus.out_beats), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single-beat vector
    send_beat("single", 8'h12, 1'b0, 1'b1);
    expect_result("single", 8'h12, 1'b0, 3'd1);

    // 10 + 20 - 5 = 25
    send_beat("three_a", 8'd10, 1'b0, 1'b0);
    send_beat("three_b", 8'd20, 1'b0, 1'b0);
    send_beat("three_c", 8'hFB, 1'b0, 1'b1);
    expect_result("three", 8'h19, 1'b0, 3'd3);

    // 100 + 50 overflows signed 8-bit, then the flag clears for the next vector
    send_beat("ovf_a", 8'd100, 1'b0, 1'b0);
    send_beat("ovf_b", 8'd50, 1'b0, 1'b1);
    expect_result("addovf", 8'h96, 1'b1, 3'd2);
    send_beat("clr_a", 8'd1, 1'b0, 1'b0);
    send_beat("clr_b", 8'd1, 1'b0, 1'b1);
    expect_result("ovfclr", 8'd2, 1'b0, 3'd2);

    // Upstream overflow flag mid-vector is sticky
    send_beat("inovf_a", 8'd3, 1'b0, 1'b0);
    send_beat("inovf_b", 8'd4, 1'b1, 1'b0);
    send_beat("inovf_c", 8'd5, 1'b0, 1'b1);
    expect_result("inovf", 8'd12, 1'b1, 3'd3);

    // Forced termination at MaxBeat, fifth beat forms its own vector
    for (int i = 0; i < 4; i++) send_beat("max", 8'd1, 1'b0, 1'b0);
    expect_result("maxbeat", 8'd4, 1'b1, 3'd4);
    send_beat("max_tail", 8'd1, 1'b0, 1'b1);
    expect_result("max_tail", 8'd1, 1'b0, 3'd1);

    // Backpressure in DONE, then retire and accept on the same edge
    send_beat("hold", 8'h21, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_data", 32'(bus.out_data), 32'h21);
      check("hold_out_beats", 32'(bus.out_beats), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bypass_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    expect_result("bypass", 8'h33, 1'b0, 3'd1);

    // Reset mid-vector with a beat presented during reset
    send_beat("rstmid_a", 8'd1, 1'b0, 1'b0);
    send_beat("rstmid_b", 8'd2, 1'b0, 1'b0);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    bus.in_last  = 1'b1;
    #1;
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_out_data", 32'(bus.out_data), 32'd0);
    check("rstmid_out_beats", 32'(bus.out_beats), 32'd0);
    check("rstmid_in_ready1", 32'(bus.in_ready), 32'd1);
    send_beat("fresh_a", 8'd7, 1'b0, 1'b0);
    send_beat("fresh_b", 8'd8, 1'b0, 1'b1);
    expect_result("fresh", 8'd15, 1'b0, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
